// File: rtl/simplebus_tx_if.sv
// rtl/simplebus_tx_if.sv - upstream handshake and simplebus line signals for simplebus_tx
interface simplebus_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             bus_a;
  logic             bus_b;
  logic             busy;

  // Producer side: offers words and observes the line.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  bus_a,
    input  bus_b,
    input  busy
  );

  // Transmitter side: accepts words and drives the line.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output bus_a,
    output bus_b,
    output busy
  );
endinterface

// File: rtl/simplebus_tx.sv
// rtl/simplebus_tx.sv - serialises WIDTH-bit words onto simplebus a/b, LSB first, even parity, one gap cycle
module simplebus_tx #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  simplebus_tx_if.slave sb
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic: upstream inputs are only looked at while idle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (sb.in_valid) begin
          shreg_d = sb.in_data;
          cnt_d   = '0;
          par_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Bit 0 is on the line this cycle; fold it into parity and move on.
        shreg_d = shreg_q >> 1;
        par_d   = par_q ^ shreg_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY;
        end
      end
      PARITY: state_d = GAP;
      GAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state, so no input-to-output path exists.
  always_comb begin
    sb.bus_a    = 1'b0;
    sb.bus_b    = 1'b0;
    sb.in_ready = 1'b0;
    sb.busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        sb.in_ready = 1'b1;
        sb.busy     = 1'b0;
      end
      SHIFT: begin
        sb.bus_a = shreg_q[0];
        sb.bus_b = 1'b1;
      end
      PARITY: begin
        sb.bus_a = par_q;
        sb.bus_b = 1'b1;
      end
      GAP: begin
        sb.bus_a = 1'b0;
        sb.bus_b = 1'b0;
      end
      default: begin
        sb.bus_a = 1'b0;
        sb.bus_b = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_simplebus_tx.sv
// tb/tb_simplebus_tx.sv - directed self-checking bench for simplebus_tx (WIDTH=8 and WIDTH=2)
module tb_simplebus_tx;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  simplebus_tx_if #(.WIDTH(8)) if8 ();
  simplebus_tx_if #(.WIDTH(2)) if2 ();

  simplebus_tx #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (if8.slave)
  );

  simplebus_tx #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the 8-bit instance's outputs as a group.
  task automatic chk8(input string tag, input logic a, input logic b, input logic rdy, input logic bsy);
    chk({tag, ".bus_a"},    {31'd0, if8.bus_a},    {31'd0, a});
    chk({tag, ".bus_b"},    {31'd0, if8.bus_b},    {31'd0, b});
    chk({tag, ".in_ready"}, {31'd0, if8.in_ready}, {31'd0, rdy});
    chk({tag, ".busy"},     {31'd0, if8.busy},     {31'd0, bsy});
  endtask

  // Called in the first SHIFT cycle. exp_bits[i] is the hand-computed i-th emitted bit.
  // With disturb set, in_valid toggles and in_data is 0xFF throughout the frame.
  // Returns in the IDLE cycle following the gap.
  task automatic frame8(input string tag, input logic [7:0] exp_bits, input logic exp_par,
                        input logic disturb);
    for (int i = 0; i < 8; i++) begin
      if (disturb) begin
        if8.in_valid = i[0];
        if8.in_data  = 8'hFF;
      end
      chk8($sformatf("%s.bit%0d", tag, i), exp_bits[i], 1'b1, 1'b0, 1'b1);
      step();
    end
    if (disturb) if8.in_valid = 1'b1;
    chk8({tag, ".parity"}, exp_par, 1'b1, 1'b0, 1'b1);
    step();
    chk8({tag, ".gap"}, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk8({tag, ".idle"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if8.in_valid = 1'b0;
    if8.in_data  = 8'h00;
    if2.in_valid = 1'b0;
    if2.in_data  = 2'b00;

    // Reset state, before any clock edge.
    #1;
    chk8("reset8", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset2.in_ready", {31'd0, if2.in_ready}, 32'd1);
    chk("reset2.busy",     {31'd0, if2.busy},     32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk8("idle_after_reset", 1'b0, 1'b0, 1'b1, 1'b0);

    // 0xA5 -> 1,0,1,0,0,1,0,1 parity 0 (encoded LSB-first as 8'hA5).
    if8.in_valid = 1'b1;
    if8.in_data  = 8'hA5;
    step();
    if8.in_valid = 1'b0;
    if8.in_data  = 8'h00;
    frame8("a5", 8'b1010_0101, 1'b0, 1'b0);
    step();

    // 0x07 -> 1,1,1,0,0,0,0,0 parity 1.
    if8.in_valid = 1'b1;
    if8.in_data  = 8'h07;
    step();
    if8.in_valid = 1'b0;
    frame8("x07", 8'b0000_0111, 1'b1, 1'b0);
    step();

    // Back-to-back 0x01 then 0xFF with in_valid held: 1,0,0,0,0,0,0,0 p1; gap; idle; 1x8 p0.
    if8.in_valid = 1'b1;
    if8.in_data  = 8'h01;
    step();
    if8.in_data  = 8'hFF;
    frame8("b2b0", 8'b0000_0001, 1'b1, 1'b0);
    step();
    if8.in_valid = 1'b0;
    frame8("b2b1", 8'b1111_1111, 1'b0, 1'b0);
    step();
    chk8("b2b_quiet", 1'b0, 1'b0, 1'b1, 1'b0);

    // 0x3C with input disturbed during the frame -> 0,0,1,1,1,1,0,0 parity 0.
    if8.in_valid = 1'b1;
    if8.in_data  = 8'h3C;
    step();
    frame8("x3c", 8'b0011_1100, 1'b0, 1'b1);
    if8.in_valid = 1'b0;
    step();
    chk8("x3c_no_reaccept", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during bit 4 of 0xFF: outputs clear without a clock edge.
    if8.in_valid = 1'b1;
    if8.in_data  = 8'hFF;
    step();
    if8.in_valid = 1'b0;
    step(); step(); step(); step();
    chk8("pre_abort_bit4", 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("async_abort", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk8("abort_held", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    if8.in_valid = 1'b1;
    if8.in_data  = 8'h80;
    step();
    if8.in_valid = 1'b0;
    frame8("x80", 8'b1000_0000, 1'b1, 1'b0);
    step();

    // WIDTH=2, 2'b10 -> 0,1 parity 1, gap, then idle: period 5 cycles.
    if2.in_valid = 1'b1;
    if2.in_data  = 2'b10;
    step();
    if2.in_valid = 1'b0;
    chk("w2.bit0.a", {31'd0, if2.bus_a}, 32'd0);
    chk("w2.bit0.b", {31'd0, if2.bus_b}, 32'd1);
    step();
    chk("w2.bit1.a", {31'd0, if2.bus_a}, 32'd1);
    chk("w2.bit1.b", {31'd0, if2.bus_b}, 32'd1);
    step();
    chk("w2.par.a", {31'd0, if2.bus_a}, 32'd1);
    chk("w2.par.b", {31'd0, if2.bus_b}, 32'd1);
    step();
    chk("w2.gap.b",     {31'd0, if2.bus_b},    32'd0);
    chk("w2.gap.ready", {31'd0, if2.in_ready}, 32'd0);
    step();
    chk("w2.idle.ready", {31'd0, if2.in_ready}, 32'd1);
    chk("w2.idle.busy",  {31'd0, if2.busy},     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
